// File: rtl/seg_adder_fu.sv
// rtl/seg_adder_fu.sv - segmented pipelined add/subtract unit, carry ripples one lane per stage
// Operands are registered at acceptance; lane s resolves in stage s, and the last stage drives the outputs.
module seg_adder_fu #(
  parameter int LANE_W    = 16,
  parameter int NUM_LANES = 4,
  parameter int SEG_W     = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_LANES*LANE_W-1:0]   a,
  input  logic [NUM_LANES*LANE_W-1:0]   b,
  input  logic [15:0]                   config_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES*LANE_W-1:0]   sum,
  output logic [NUM_LANES-1:0]          carry_out,
  output logic [NUM_LANES-1:0]          ovf,
  output logic [3:0]                    dest_info
);

  localparam int W     = NUM_LANES * LANE_W;
  localparam int LOG2N = $clog2(NUM_LANES);
  localparam int IW    = LOG2N + 1;
  localparam logic [SEG_W-1:0] K_MAX = SEG_W'(LOG2N);

  logic                 w_en;
  logic [SEG_W-1:0]     w_k_raw;
  logic [SEG_W-1:0]     w_k_clamp;
  logic                 w_sub;
  logic [3:0]           w_dest;
  logic [W-1:0]         w_b_eff;
  logic                 w_unused_cfg;

  logic                 r_in_valid;
  logic [SEG_W-1:0]     r_in_k;
  logic                 r_in_sub;
  logic [3:0]           r_in_dest;
  logic [W-1:0]         r_in_a;
  logic [W-1:0]         r_in_b;

  assign w_en         = !out_valid || out_ready;
  assign in_ready     = w_en;
  assign w_k_raw      = config_in[SEG_W-1:0];
  assign w_k_clamp    = (w_k_raw > K_MAX) ? K_MAX : w_k_raw;
  assign w_sub        = config_in[SEG_W];
  assign w_dest       = config_in[SEG_W+4:SEG_W+1];
  assign w_b_eff      = w_sub ? ~b : b;
  assign w_unused_cfg = &{1'b0, config_in[15:SEG_W+5]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_valid <= 1'b0;
      r_in_k     <= '0;
      r_in_sub   <= 1'b0;
      r_in_dest  <= '0;
      r_in_a     <= '0;
      r_in_b     <= '0;
    end else if (w_en) begin
      r_in_valid <= in_valid;
      r_in_k     <= w_k_clamp;
      r_in_sub   <= w_sub;
      r_in_dest  <= w_dest;
      r_in_a     <= a;
      r_in_b     <= w_b_eff;
    end
  end

  for (genvar s = 0; s < NUM_LANES; s++) begin : g_stage
    localparam logic [IW-1:0] LANE_IDX = IW'(s);

    logic                 r_valid;
    logic [3:0]           r_dest;
    logic [W-1:0]         r_sum;
    logic [NUM_LANES-1:0] r_co;
    logic [NUM_LANES-1:0] r_ov;

    logic                 w_v_in;
    logic [SEG_W-1:0]     w_k_in;
    logic                 w_sub_in;
    logic [3:0]           w_dest_in;
    logic [W-1:0]         w_a_in;
    logic [W-1:0]         w_b_in;
    logic [W-1:0]         w_sum_in;
    logic                 w_cy_in;
    logic [NUM_LANES-1:0] w_co_in;
    logic [NUM_LANES-1:0] w_ov_in;

    logic [IW-1:0]        w_mask;
    logic                 w_start;
    logic                 w_top;
    logic                 w_cin;
    logic [LANE_W-1:0]    w_a_lane;
    logic [LANE_W-1:0]    w_b_lane;
    logic [LANE_W:0]      w_res;
    logic                 w_ov_bit;
    logic [W-1:0]         w_sum_nx;
    logic [NUM_LANES-1:0] w_co_nx;
    logic [NUM_LANES-1:0] w_ov_nx;

    if (s == 0) begin : g_src
      assign w_v_in    = r_in_valid;
      assign w_k_in    = r_in_k;
      assign w_sub_in  = r_in_sub;
      assign w_dest_in = r_in_dest;
      assign w_a_in    = r_in_a;
      assign w_b_in    = r_in_b;
      assign w_sum_in  = '0;
      assign w_cy_in   = 1'b0;
      assign w_co_in   = '0;
      assign w_ov_in   = '0;
    end else begin : g_src
      assign w_v_in    = g_stage[s-1].r_valid;
      assign w_k_in    = g_stage[s-1].g_fwd.r_k;
      assign w_sub_in  = g_stage[s-1].g_fwd.r_sub;
      assign w_dest_in = g_stage[s-1].r_dest;
      assign w_a_in    = g_stage[s-1].g_fwd.r_a;
      assign w_b_in    = g_stage[s-1].g_fwd.r_b;
      assign w_sum_in  = g_stage[s-1].r_sum;
      assign w_cy_in   = g_stage[s-1].g_fwd.r_cy;
      assign w_co_in   = g_stage[s-1].r_co;
      assign w_ov_in   = g_stage[s-1].r_ov;
    end

    // Lane position within its segment decides start/top roles.
    assign w_mask   = (IW'(1) << w_k_in) - IW'(1);
    assign w_start  = (LANE_IDX & w_mask) == '0;
    assign w_top    = (LANE_IDX & w_mask) == w_mask;
    assign w_cin    = w_start ? w_sub_in : w_cy_in;
    assign w_a_lane = w_a_in[s*LANE_W +: LANE_W];
    assign w_b_lane = w_b_in[s*LANE_W +: LANE_W];
    assign w_res    = {1'b0, w_a_lane} + {1'b0, w_b_lane} + {{LANE_W{1'b0}}, w_cin};
    assign w_ov_bit = w_top && (w_a_lane[LANE_W-1] == w_b_lane[LANE_W-1])
                      && (w_res[LANE_W-1] != w_a_lane[LANE_W-1]);

    always_comb begin
      w_sum_nx = w_sum_in;
      w_co_nx  = w_co_in;
      w_ov_nx  = w_ov_in;
      w_sum_nx[s*LANE_W +: LANE_W] = w_res[LANE_W-1:0];
      w_co_nx[s] = w_top & w_res[LANE_W];
      w_ov_nx[s] = w_ov_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_dest  <= '0;
        r_sum   <= '0;
        r_co    <= '0;
        r_ov    <= '0;
      end else if (w_en) begin
        r_valid <= w_v_in;
        r_dest  <= w_dest_in;
        r_sum   <= w_sum_nx;
        r_co    <= w_co_nx;
        r_ov    <= w_ov_nx;
      end
    end

    // Only non-final stages carry operands, mode and the lane carry onward.
    if (s < NUM_LANES - 1) begin : g_fwd
      logic [SEG_W-1:0] r_k;
      logic             r_sub;
      logic [W-1:0]     r_a;
      logic [W-1:0]     r_b;
      logic             r_cy;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_k   <= '0;
          r_sub <= 1'b0;
          r_a   <= '0;
          r_b   <= '0;
          r_cy  <= 1'b0;
        end else if (w_en) begin
          r_k   <= w_k_in;
          r_sub <= w_sub_in;
          r_a   <= w_a_in;
          r_b   <= w_b_in;
          r_cy  <= w_res[LANE_W];
        end
      end
    end
  end

  assign out_valid = g_stage[NUM_LANES-1].r_valid;
  assign sum       = g_stage[NUM_LANES-1].r_sum;
  assign carry_out = g_stage[NUM_LANES-1].r_co;
  assign ovf       = g_stage[NUM_LANES-1].r_ov;
  assign dest_info = g_stage[NUM_LANES-1].r_dest;

endmodule

// File: tb/tb_seg_adder_fu.sv
// tb/tb_seg_adder_fu.sv - directed bench for seg_adder_fu (LANE_W=16, NUM_LANES=4)
module tb_seg_adder_fu;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [15:0] config_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic [3:0]  carry_out;
  logic [3:0]  ovf;
  logic [3:0]  dest_info;

  int total = 0;
  int bad   = 0;

  seg_adder_fu #(.LANE_W(16), .NUM_LANES(4), .SEG_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .config_in(config_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .ovf(ovf), .dest_info(dest_info)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mkcfg(input int k, input int sub, input int dest);
    return 16'((dest << 4) | (sub << 3) | k);
  endfunction

  // Shared back-to-back pattern: same operands, modes k=0,1,2,0, dest 1..4.
  logic [63:0] b2b_a    = 64'h0001_FFFF_FFFF_FFFF;
  logic [63:0] b2b_b    = 64'h0000_0001_0000_0001;
  logic [63:0] b2b_sum [4] = '{64'h0001_0000_FFFF_0000, 64'h0002_0000_0000_0000,
                               64'h0002_0001_0000_0000, 64'h0001_0000_FFFF_0000};
  logic [3:0]  b2b_co  [4] = '{4'b0101, 4'b0010, 4'b0000, 4'b0101};
  int          b2b_k   [4] = '{0, 1, 2, 0};

  task automatic run_one(input logic [63:0] ta, input logic [63:0] tb_v, input logic [15:0] cfg,
                         output logic [63:0] osum, output logic [3:0] oco, output logic [3:0] oov,
                         output logic [3:0] odest, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; config_in = cfg; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    osum = sum; oco = carry_out; oov = ovf; odest = dest_info;
  endtask

  // Drives four ops on consecutive edges; returns at the negedge after the fourth accept.
  task automatic issue4();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      a = b2b_a; b = b2b_b; config_in = mkcfg(b2b_k[j], 0, j + 1); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; config_in = '0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (sum !== 64'h0) begin bad++; $display("FAIL rst_sum got=%h exp=0", sum); end
    total++; if ({carry_out, ovf, dest_info} !== 12'h0) begin bad++; $display("FAIL rst_flags got=%h exp=0", {carry_out, ovf, dest_info}); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_k0_add();
    logic [63:0] s; logic [3:0] co, ov, d; int lat;
    run_one(64'h0003_0002_0001_FFFF, 64'h0001_0001_0001_0001, mkcfg(0, 0, 5), s, co, ov, d, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL k0_latency got=%0d exp=4", lat); end
    total++; if (s !== 64'h0004_0003_0002_0000) begin bad++; $display("FAIL k0_sum got=%h exp=0004000300020000", s); end
    total++; if (co !== 4'b0001) begin bad++; $display("FAIL k0_carry got=%b exp=0001", co); end
    total++; if (ov !== 4'b0000) begin bad++; $display("FAIL k0_ovf got=%b exp=0000", ov); end
    total++; if (d !== 4'd5) begin bad++; $display("FAIL k0_dest got=%0d exp=5", d); end
  endtask

  task automatic test_k2_add();
    logic [63:0] s; logic [3:0] co, ov, d; int lat;
    run_one(64'h0000_FFFF_FFFF_FFFF, 64'h1, mkcfg(2, 0, 6), s, co, ov, d, lat);
    total++; if (s !== 64'h0001_0000_0000_0000) begin bad++; $display("FAIL k2_sum got=%h exp=0001000000000000", s); end
    total++; if (co !== 4'b0000) begin bad++; $display("FAIL k2_carry got=%b exp=0000", co); end
    total++; if (lat !== 4) begin bad++; $display("FAIL k2_latency got=%0d exp=4", lat); end
    run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, mkcfg(2, 0, 7), s, co, ov, d, lat);
    total++; if (s !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL k2_ovf_sum got=%h exp=8000000000000000", s); end
    total++; if (ov !== 4'b1000) begin bad++; $display("FAIL k2_ovf got=%b exp=1000", ov); end
    // k above log2(NUM_LANES) clamps to one 64-bit segment
    run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, mkcfg(7, 0, 8), s, co, ov, d, lat);
    total++; if (s !== 64'h0) begin bad++; $display("FAIL clamp_sum got=%h exp=0", s); end
    total++; if (co !== 4'b1000) begin bad++; $display("FAIL clamp_carry got=%b exp=1000", co); end
    total++; if (d !== 4'd8) begin bad++; $display("FAIL clamp_dest got=%0d exp=8", d); end
  endtask

  task automatic test_k1_sub();
    logic [63:0] s; logic [3:0] co, ov, d; int lat;
    run_one(64'h0000_0001_0000_0001, 64'h0000_0002_0000_0002, mkcfg(1, 1, 9), s, co, ov, d, lat);
    total++; if (s !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL sub_borrow_sum got=%h exp=FFFFFFFFFFFFFFFF", s); end
    total++; if (co !== 4'b0000) begin bad++; $display("FAIL sub_borrow_carry got=%b exp=0000", co); end
    run_one(64'h0000_0005_0000_0005, 64'h0000_0003_0000_0003, mkcfg(1, 1, 10), s, co, ov, d, lat);
    total++; if (s !== 64'h0000_0002_0000_0002) begin bad++; $display("FAIL sub_sum got=%h exp=0000000200000002", s); end
    total++; if (co !== 4'b1010) begin bad++; $display("FAIL sub_carry got=%b exp=1010", co); end
    run_one(64'h0000_0000_8000_0000, 64'h0000_0000_0000_0001, mkcfg(1, 1, 11), s, co, ov, d, lat);
    total++; if (s !== 64'h0000_0000_7FFF_FFFF) begin bad++; $display("FAIL sub_ovf_sum got=%h exp=000000007FFFFFFF", s); end
    total++; if (ov !== 4'b0010) begin bad++; $display("FAIL sub_ovf got=%b exp=0010", ov); end
    total++; if (co !== 4'b1010) begin bad++; $display("FAIL sub_ovf_carry got=%b exp=1010", co); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    issue4();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_early got=%b exp=0", out_valid); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d got=%b exp=1", j, out_valid); end
      total++; if (sum !== b2b_sum[j]) begin bad++; $display("FAIL b2b_sum%0d got=%h exp=%h", j, sum, b2b_sum[j]); end
      total++; if (carry_out !== b2b_co[j]) begin bad++; $display("FAIL b2b_carry%0d got=%b exp=%b", j, carry_out, b2b_co[j]); end
      total++; if (dest_info !== 4'(j + 1)) begin bad++; $display("FAIL b2b_dest%0d got=%0d exp=%0d", j, dest_info, j + 1); end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    issue4();
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready%0d got=%b exp=0", c, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid%0d got=%b exp=1", c, out_valid); end
      total++; if (sum !== b2b_sum[0]) begin bad++; $display("FAIL stall_sum%0d got=%h exp=%h", c, sum, b2b_sum[0]); end
      total++; if (dest_info !== 4'd1) begin bad++; $display("FAIL stall_dest%0d got=%0d exp=1", c, dest_info); end
    end
    out_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid%0d got=%b exp=1", j, out_valid); end
      total++; if (sum !== b2b_sum[j]) begin bad++; $display("FAIL drain_sum%0d got=%h exp=%h", j, sum, b2b_sum[j]); end
      total++; if (dest_info !== 4'(j + 1)) begin bad++; $display("FAIL drain_dest%0d got=%0d exp=%0d", j, dest_info, j + 1); end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_tail got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] s; logic [3:0] co, ov, d; int lat;
    out_ready = 1'b1;
    issue4();
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_premise got=%b exp=1", out_valid); end
    #2 reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    total++; if (sum !== 64'h0) begin bad++; $display("FAIL mid_rst_sum got=%h exp=0", sum); end
    total++; if ({carry_out, dest_info} !== 8'h0) begin bad++; $display("FAIL mid_rst_flags got=%h exp=0", {carry_out, dest_info}); end
    reset = 1'b0;
    run_one(64'h0003_0002_0001_FFFF, 64'h0001_0001_0001_0001, mkcfg(0, 0, 12), s, co, ov, d, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL mid_latency got=%0d exp=4", lat); end
    total++; if (s !== 64'h0004_0003_0002_0000) begin bad++; $display("FAIL mid_sum got=%h exp=0004000300020000", s); end
    total++; if (d !== 4'd12) begin bad++; $display("FAIL mid_dest got=%0d exp=12", d); end
  endtask

  initial begin
    test_reset();
    test_k0_add();
    test_k2_add();
    test_k1_sub();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
